data_mem_arbiter: RTL and testbench

Two-port arbiter and access sequencer in front of the single-port, byte-addressed data memory (combinational 32-bit read, 32-bit write on `clk`). It shares the memory between requester 0 (CPU load/store path) and requester 1 (DMA/test loader). It turns byte and halfword stores into read-modify-write sequences, because the memory only writes whole 32-bit words.

---
 rtl/data_mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_data_mem_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares a single-port word memory between two requesters
// and sequences byte/halfword stores as read-modify-write.
// Optional macro DMEM_ARB_RR_EN: round-robin arbitration on simultaneous
// requests. When undefined, port 0 always wins a tie.
//
// state | meaning
// IDLE  | waiting for a request; arbitrate and latch the winner
// RD    | memory read: load capture or sub-word merge
// WR    | memory write of the final word
// RESP  | done pulse to the owning port
module data_mem_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0,
  input  logic                     req1,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [1:0]               size0,
  input  logic [1:0]               size1,
  input  logic [ADDRESS_WIDTH-1:0] addr0,
  input  logic [ADDRESS_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]    wdata0,
  input  logic [DATA_WIDTH-1:0]    wdata1,
  output logic                     gnt0,
  output logic                     gnt1,
  output logic                     done0,
  output logic                     done1,
  output logic [DATA_WIDTH-1:0]    rdata0,
  output logic [DATA_WIDTH-1:0]    rdata1,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0]    mem_wd,
  input  logic [DATA_WIDTH-1:0]    mem_rd
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    any_req;
  logic                    win;
  logic                    id_q;
  logic                    we_q;
  logic [1:0]              size_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    sel_we;
  logic [1:0]              sel_size;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic [DATA_WIDTH-1:0]   merged;

  assign any_req = req0 | req1;

`ifdef DMEM_ARB_RR_EN
  logic last_q;

  // Winner select: a lone request always wins, a tie goes to the port not granted last.
  always_comb begin
    win = 1'b0;
    if (req0 && req1) win = ~last_q;
    else              win = ~req0;
  end

  // Last-granted pointer; reset to 1 so port 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        last_q <= 1'b1;
    else if (state == IDLE && any_req) last_q <= win;
  end
`else
  // Fixed priority: port 1 wins only when port 0 is not requesting.
  always_comb begin
    win = ~req0;
  end
`endif

  assign sel_we    = win ? we1    : we0;
  assign sel_size  = win ? size1  : size0;
  assign sel_addr  = win ? addr1  : addr0;
  assign sel_wdata = win ? wdata1 : wdata0;

  // Store data merged into the word read back in RD.
  always_comb begin
    case (size_q)
      2'b00:   merged = {mem_rd[DATA_WIDTH-1:8],  wdata_q[7:0]};
      2'b01:   merged = {mem_rd[DATA_WIDTH-1:16], wdata_q[15:0]};
      default: merged = wdata_q;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: word stores skip the read phase.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (any_req) state_nxt = (sel_we && sel_size[1]) ? WR : RD;
      RD:   state_nxt = we_q ? WR : RESP;
      WR:   state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, grant pulse, memory address/data and load return registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      wdata_q <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      mem_a   <= '0;
      mem_wd  <= '0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      if (state == IDLE && any_req) begin
        id_q    <= win;
        we_q    <= sel_we;
        size_q  <= sel_size;
        wdata_q <= sel_wdata;
        mem_a   <= sel_addr;
        mem_wd  <= sel_wdata;
        gnt0    <= ~win;
        gnt1    <= win;
      end else if (state == RD) begin
        if (we_q)      mem_wd <= merged;
        else if (id_q) rdata1 <= mem_rd;
        else           rdata0 <= mem_rd;
      end
    end
  end

  assign mem_we = (state == WR);
  assign done0  = (state == RESP) && !id_q;
  assign done1  = (state == RESP) &&  id_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: directed test-plan cases, an
// arbitration-order case, randomized traffic and a mid-transaction reset.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [1:0]  size0, size1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1;
  logic [31:0] rdata0, rdata1;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gap;
    bit          abort;
  } cmd_t;

  typedef struct {
    bit          is_load;
    logic [31:0] rdata;
    logic [31:0] wd;
    logic [31:0] wa;
    int          lat;
    bit          chk_req;
  } exp_t;

  cmd_t cq0[$], cq1[$];
  exp_t sb0[$], sb1[$];
  int   glog[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   req_cyc0, req_cyc1;
  bit   tmo0, tmo1;

  logic [31:0] mem_arr [0:4095];
  logic [31:0] mdl [int];
  logic        pre_en, mem_clr;
  logic [31:0] pre_a, pre_d;

`ifdef DMEM_ARB_RR_EN
  int exp_g[4] = '{0, 1, 0, 1};
`else
  int exp_g[4] = '{0, 0, 0, 0};
`endif

  data_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .size0(size0), .size1(size1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bench memory: combinational read, clocked write, plus preload/clear ports.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) mem_arr[i] <= 32'h0;
    end else if (mem_we) begin
      mem_arr[mem_a[13:2]] <= mem_wd;
    end else if (pre_en) begin
      mem_arr[pre_a[13:2]] <= pre_d;
    end
  end
  assign mem_rd = mem_arr[mem_a[13:2]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] mdl_rd(input int idx);
    return mdl.exists(idx) ? mdl[idx] : 32'h0;
  endfunction

  // Reference model: a load returns the whole word; a store replaces the low
  // byte, low half or whole word; sub-word stores take one extra cycle.
  function automatic exp_t model(input cmd_t c);
    exp_t        e;
    int          idx = int'(c.addr[13:2]);
    logic [31:0] old = mdl_rd(idx);
    logic [31:0] nw;
    e.is_load = !c.we;
    e.rdata   = old;
    e.wa      = c.addr;
    e.chk_req = 1'b0;
    e.wd      = 32'h0;
    e.lat     = 1;
    if (c.we) begin
      case (c.size)
        2'd0:    nw = {old[31:8], c.wdata[7:0]};
        2'd1:    nw = {old[31:16], c.wdata[15:0]};
        default: nw = c.wdata;
      endcase
      e.lat    = (c.size < 2'd2) ? 2 : 1;
      e.wd     = nw;
      mdl[idx] = nw;
    end
    return e;
  endfunction

  function automatic cmd_t mk(input logic we, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata);
    cmd_t c;
    c.we = we; c.size = size; c.addr = addr; c.wdata = wdata;
    c.gap = 0; c.abort = 1'b0;
    return c;
  endfunction

  task automatic issue(input int p, input cmd_t c, input exp_t e);
    if (p == 0) begin cq0.push_back(c); sb0.push_back(e); end
    else        begin cq1.push_back(c); sb1.push_back(e); end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pre_a = a; pre_d = d; pre_en = 1'b1;
    @(posedge clk); #1;
    pre_en = 1'b0;
    mdl[int'(a[13:2])] = d;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((cq0.size() != 0 || cq1.size() != 0 || sb0.size() != 0 || sb1.size() != 0) && n < 20000) begin
      @(posedge clk); n++;
    end
    #1;
    check("wait_idle_timeout", 32'(n >= 20000), 32'h0);
  endtask

  // Requester 0 driver.
  initial begin
    cmd_t c;
    int   n;
    req0 = 0; we0 = 0; size0 = 0; addr0 = 0; wdata0 = 0; tmo0 = 0; req_cyc0 = 0;
    @(posedge clk); #2;
    forever begin
      while (cq0.size() == 0) begin @(posedge clk); #2; end
      c = cq0.pop_front();
      for (int k = 0; k < c.gap; k++) begin @(posedge clk); #2; end
      we0 = c.we; size0 = c.size; addr0 = c.addr; wdata0 = c.wdata;
      req0 = 1'b1; req_cyc0 = cyc;
      n = 0;
      do begin @(negedge clk); n++; end while (!gnt0 && n < 300);
      if (!gnt0) tmo0 = 1'b1;
      @(posedge clk); #2;
      req0 = 1'b0; we0 = 1'($urandom); addr0 = $urandom; wdata0 = $urandom;
      if (!c.abort) begin
        n = 0;
        do begin @(negedge clk); n++; end while (!done0 && n < 300);
        if (!done0) tmo0 = 1'b1;
        @(posedge clk); #2;
      end
    end
  end

  // Requester 1 driver.
  initial begin
    cmd_t c;
    int   n;
    req1 = 0; we1 = 0; size1 = 0; addr1 = 0; wdata1 = 0; tmo1 = 0; req_cyc1 = 0;
    @(posedge clk); #2;
    forever begin
      while (cq1.size() == 0) begin @(posedge clk); #2; end
      c = cq1.pop_front();
      for (int k = 0; k < c.gap; k++) begin @(posedge clk); #2; end
      we1 = c.we; size1 = c.size; addr1 = c.addr; wdata1 = c.wdata;
      req1 = 1'b1; req_cyc1 = cyc;
      n = 0;
      do begin @(negedge clk); n++; end while (!gnt1 && n < 300);
      if (!gnt1) tmo1 = 1'b1;
      @(posedge clk); #2;
      req1 = 1'b0; we1 = 1'($urandom); addr1 = $urandom; wdata1 = $urandom;
      if (!c.abort) begin
        n = 0;
        do begin @(negedge clk); n++; end while (!done1 && n < 300);
        if (!done1) tmo1 = 1'b1;
        @(posedge clk); #2;
      end
    end
  end

  int          gcyc = 0;
  int          wcnt = 0;
  logic [31:0] wd_s = 0;
  logic [31:0] wa_s = 0;

  task automatic mon_done(input int p);
    exp_t        e;
    logic [31:0] rd;
    int          rc;
    if ((p == 0 && sb0.size() == 0) || (p == 1 && sb1.size() == 0)) begin
      n_chk++;
      $display("FAIL done%0d_unexpected: got done with no outstanding request, expected none", p);
      return;
    end
    e  = (p == 0) ? sb0.pop_front() : sb1.pop_front();
    rd = (p == 0) ? rdata0 : rdata1;
    rc = (p == 0) ? req_cyc0 : req_cyc1;
    check($sformatf("done%0d_latency", p), 32'(cyc - gcyc), 32'(e.lat));
    check($sformatf("done%0d_we_cycles", p), 32'(wcnt), e.is_load ? 32'h0 : 32'h1);
    if (e.is_load) begin
      check($sformatf("rdata%0d", p), rd, e.rdata);
    end else begin
      check($sformatf("mem_wd%0d", p), wd_s, e.wd);
      check($sformatf("mem_a%0d", p), wa_s, e.wa);
    end
    if (e.chk_req) check($sformatf("gnt%0d_latency", p), 32'(gcyc - rc), 32'h1);
  endtask

  // Monitor: logs grants, tracks write cycles, scores each done pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (gnt0 || gnt1) begin
          glog.push_back(gnt1 ? 1 : 0);
          gcyc = cyc;
          wcnt = 0;
        end
        if (mem_we) begin
          wcnt++;
          wd_s = mem_wd;
          wa_s = mem_a;
        end
        if (done0) mon_done(0);
        if (done1) mon_done(1);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1);
  end

  // Main sequence.
  initial begin
    cmd_t c;
    exp_t e;
    int   n;
    rst = 1'b1; pre_en = 1'b0; pre_a = 0; pre_d = 0; mem_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mem_clr = 1'b0;
    check("rst_gnt0", 32'(gnt0), 32'h0);
    check("rst_gnt1", 32'(gnt1), 32'h0);
    check("rst_done0", 32'(done0), 32'h0);
    check("rst_done1", 32'(done1), 32'h0);
    check("rst_rdata0", rdata0, 32'h0);
    check("rst_rdata1", rdata1, 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_wd", mem_wd, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Word store then load on port 0.
    c = mk(1'b1, 2'd2, 32'h10000, 32'hDEADBEEF);
    e = model(c); e.wd = 32'hDEADBEEF; e.chk_req = 1'b1;
    issue(0, c, e);
    c = mk(1'b0, 2'd2, 32'h10000, 32'h0);
    e = model(c); e.rdata = 32'hDEADBEEF; e.chk_req = 1'b1;
    issue(0, c, e);
    wait_idle();

    // Byte store merge on port 1.
    preload(32'h10004, 32'h11223344);
    c = mk(1'b1, 2'd0, 32'h10004, 32'hFFFFFFAB);
    e = model(c); e.wd = 32'h112233AB; e.chk_req = 1'b1;
    issue(1, c, e);
    c = mk(1'b0, 2'd2, 32'h10004, 32'h0);
    e = model(c); e.rdata = 32'h112233AB; e.chk_req = 1'b1;
    issue(1, c, e);
    wait_idle();

    // Half store merge on port 0.
    preload(32'h10008, 32'h11223344);
    c = mk(1'b1, 2'd1, 32'h10008, 32'h00005566);
    e = model(c); e.wd = 32'h11225566; e.chk_req = 1'b1;
    issue(0, c, e);
    c = mk(1'b0, 2'd2, 32'h10008, 32'h0);
    e = model(c); e.rdata = 32'h11225566; e.chk_req = 1'b1;
    issue(0, c, e);
    wait_idle();

    // Simultaneous back-to-back loads from both ports.
    glog.delete();
    for (int k = 0; k < 4; k++) begin
      c = mk(1'b0, 2'd2, 32'h10000, 32'h0);
      issue(0, c, model(c));
      c = mk(1'b0, 2'd2, 32'h10004, 32'h0);
      issue(1, c, model(c));
    end
    wait_idle();
    for (int k = 0; k < 4; k++)
      check($sformatf("grant_order_%0d", k), (glog.size() > k) ? 32'(glog[k]) : 32'hFFFFFFFF, 32'(exp_g[k]));

    // Randomized traffic in disjoint per-port regions.
    for (int k = 0; k < 40; k++) begin
      c = mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 32'h11000 + $urandom_range(0, 255), $urandom);
      c.gap = $urandom_range(0, 3);
      issue(0, c, model(c));
      c = mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 32'h12000 + $urandom_range(0, 255), $urandom);
      c.gap = $urandom_range(0, 3);
      issue(1, c, model(c));
    end
    wait_idle();

    // Reset during the read phase of a byte store.
    preload(32'h1000C, 32'h01020304);
    c = mk(1'b1, 2'd0, 32'h1000C, 32'hFFFFFFAB);
    c.abort = 1'b1;
    cq1.push_back(c);
    n = 0;
    do begin @(negedge clk); n++; end while (!gnt1 && n < 50);
    check("abort_gnt1_seen", 32'(gnt1), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    check("abort_gnt0", 32'(gnt0), 32'h0);
    check("abort_gnt1", 32'(gnt1), 32'h0);
    check("abort_done0", 32'(done0), 32'h0);
    check("abort_done1", 32'(done1), 32'h0);
    check("abort_rdata0", rdata0, 32'h0);
    check("abort_rdata1", rdata1, 32'h0);
    check("abort_mem_we", 32'(mem_we), 32'h0);
    check("abort_mem_a", mem_a, 32'h0);
    check("abort_mem_wd", mem_wd, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("abort_mem_word", mem_arr[3], 32'h01020304);

    // Fresh load after reset: starts from IDLE with normal latency.
    c = mk(1'b0, 2'd2, 32'h1000C, 32'h0);
    e = model(c); e.rdata = 32'h01020304; e.chk_req = 1'b1;
    issue(1, c, e);
    wait_idle();

    check("driver_timeouts", 32'(tmo0 | tmo1), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
